router_out_arbiter: RTL and testbench
=====================================

Name: router_out_arbiter

Overview:
- Per-output-port packet-level switch allocator and output stage for the 4-port wormhole router.
- Arbitrates round-robin among input ports whose head-of-line flit targets this output.
- Locks the grant from HEAD flit to TAIL flit and muxes the granted input's flits into a registered output with valid/ready handshake.
- One instance per output port, between the input buffers/route compute and the link.

Parameters:
- NUM_OF_PORTS, 4, number of requesting input ports.
- FLIT_SIZE, 19, flit width: bit 18 = valid, bits 17:16 = flit type (0 HEAD, 1 TAIL, 2 BODY, 3 NONE), bits 15:0 = address/data.
- NUM_OF_FLITS, 4, flits per packet: HEAD, BODY, BODY, TAIL.
- WD_TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_i  in  NUM_OF_PORTS  input i has a head-of-line flit routed to this output
- flit_i  in  NUM_OF_PORTS*FLIT_SIZE  flattened head-of-line flits; input i occupies bits [i*FLIT_SIZE +: FLIT_SIZE]
- pop_o  out  NUM_OF_PORTS  one-hot; flit of input i consumed this cycle
- grant_o  out  NUM_OF_PORTS  one-hot current owner; all zero when IDLE
- out_flit_o  out  FLIT_SIZE  registered output flit
- out_valid_o  out  1  out_flit_o valid
- out_ready_i  in  1  downstream accepts out_flit_o
- state_o  out  2  IDLE=0, ROUTING=1 (unused, never entered), ACTIVE=2, WAITING=3
- err_o  out  1  sticky protocol error

Behaviour:
- Reset: state IDLE; grant_o=0; pop_o=0; out_valid_o=0; out_flit_o=0; err_o=0; RR pointer=0; flit counter=0.
- Eligibility: input i is eligible when req_i[i]=1, flit valid bit=1 and type=HEAD.
- IDLE:
  - Select the first eligible input scanning ptr, ptr+1, ... mod NUM_OF_PORTS.
  - Register the winner into grant_o and go to ACTIVE next cycle. Arbitration latency is 1 cycle.
  - No pop occurs in IDLE.
  - Non-HEAD requests are ignored.
- Output register load condition: load = (!out_valid_o || out_ready_i).
- ACTIVE, granted input g:
  - If req_i[g] && flit valid && load: pop_o[g]=1 (combinational, same cycle), out_flit_o<=flit_i[g], out_valid_o<=1, flit counter++.
  - Else if load and the flit is absent: out_valid_o<=0 and go to WAITING.
  - Throughput is 1 flit/cycle.
- WAITING:
  - Grant held, no pop.
  - Return to ACTIVE and pop in the same cycle as soon as req_i[g] && valid && load.
- Release:
  - When a TAIL flit is popped, the next state is IDLE, grant_o clears, ptr<=(g+1) mod NUM_OF_PORTS, counter<=0.
  - The output register still drains normally.
  - One bubble cycle between packets.
- Flit counter (2 bits):
  - If the 4th popped flit (counter==3) is not TAIL: set err_o and force release as above.
  - A HEAD popped mid-packet (counter!=0) also sets err_o; the flit is still forwarded.
- Backpressure: while out_valid_o && !out_ready_i, out_flit_o/out_valid_o hold stable and no pop occurs.
- Simultaneous TAIL pop and new eligible requests: new requests are only evaluated in the following IDLE cycle.
- pop_o is never asserted for a non-granted input. grant_o is one-hot or zero at all times.
- Reset mid-packet: immediate async clear of all state; a partially forwarded packet is dropped with no recovery.

Optional Feature:
- Macro ROUTER_ARB_WATCHDOG_EN.
- Defined:
  - A counter increments each cycle in WAITING and clears on any pop.
  - When it reaches WD_TIMEOUT: set err_o, release the grant (IDLE, ptr advance, counter clear).
- Undefined: no counter; WAITING may last indefinitely; err_o is driven only by protocol errors.

Test Plan:
- Reset, then req_i=0001 with flits HEAD(0x0012), BODY(0xAAAA), BODY(0xBBBB), TAIL, out_ready_i=1 -> grant_o=0001 at cycle 1; pop_o[0] cycles 1-4; out_flit_o carries 4 flits in order at cycles 2-5; IDLE at cycle 5; err_o=0.
- req_i=1111, all HEAD, 3 packets back to back, ptr=0 -> grants in order 0001, 0010, 0100, with 1 IDLE cycle between packets.
- Mid-packet out_ready_i=0 for 3 cycles -> out_flit_o stable, pop_o=0, no flit lost or duplicated.
- Granted input drops req_i after BODY for 5 cycles -> state_o=3 (WAITING), grant held, other HEAD requests not granted; resumes forwarding on return.
- Packet HEAD, BODY, BODY, BODY -> err_o=1 after the 4th pop, grant released, next arbitration proceeds.
- With ROUTER_ARB_WATCHDOG_EN and WD_TIMEOUT=64: granted input stalls in WAITING -> release and err_o=1 exactly 64 cycles after entering WAITING. Without the macro: still WAITING at cycle 200.

Source files
------------

// File: rtl/router_out_arbiter.sv
// -----------------------------------------------------------------------------
// router_out_arbiter
//
// Packet-level switch allocator and output stage for one output port of the
// 4-port wormhole router. It arbitrates round-robin among inputs whose
// head-of-line flit is a HEAD targeting this output. The grant is held from
// HEAD to TAIL. The granted input's flits pass into a registered output with a
// valid/ready handshake.
//
// Flit format (FLIT_SIZE = 19):
//   [18] valid, [17:16] type (0 HEAD, 1 TAIL, 2 BODY, 3 NONE), [15:0] payload
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   req_i        per-input request: head-of-line flit is routed here
//   flit_i       flattened head-of-line flits, input i at [i*FLIT_SIZE +: FLIT_SIZE]
//   pop_o        one-hot, combinational: flit of input i consumed this cycle
//   grant_o      one-hot current owner, zero when IDLE
//   out_flit_o   registered output flit
//   out_valid_o  out_flit_o is valid
//   out_ready_i  downstream accepts out_flit_o
//   state_o      IDLE=0, ROUTING=1 (never entered), ACTIVE=2, WAITING=3
//   err_o        sticky protocol error
//
// Optional feature: define ROUTER_ARB_WATCHDOG_EN to add a WAITING-state
// watchdog. The watchdog forces a release and sets err_o after WD_TIMEOUT
// stalled cycles.
// -----------------------------------------------------------------------------
module router_out_arbiter #(
    parameter int NUM_OF_PORTS = 4,
    parameter int FLIT_SIZE    = 19,
    parameter int NUM_OF_FLITS = 4,
    parameter int WD_TIMEOUT   = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_OF_PORTS-1:0]           req_i,
    input  logic [NUM_OF_PORTS*FLIT_SIZE-1:0] flit_i,
    output logic [NUM_OF_PORTS-1:0]           pop_o,
    output logic [NUM_OF_PORTS-1:0]           grant_o,
    output logic [FLIT_SIZE-1:0]              out_flit_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [1:0]                        state_o,
    output logic                              err_o
);

    localparam int PW = (NUM_OF_PORTS > 1) ? $clog2(NUM_OF_PORTS) : 1;
    localparam int CW = (NUM_OF_FLITS > 1) ? $clog2(NUM_OF_FLITS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTING = 2'd1,
        ACTIVE  = 2'd2,
        WAITING = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        TYPE_HEAD = 2'd0,
        TYPE_TAIL = 2'd1,
        TYPE_BODY = 2'd2,
        TYPE_NONE = 2'd3
    } flit_type_t;

    state_t                  state;
    logic [NUM_OF_PORTS-1:0] grant;
    logic [PW-1:0]           gidx;
    logic [PW-1:0]           ptr;
    logic [CW-1:0]           cnt;
    logic [FLIT_SIZE-1:0]    out_flit;
    logic                    out_valid;
    logic                    err;

    logic [NUM_OF_PORTS-1:0] eligible;
    logic [PW-1:0]           cand;
    logic [PW-1:0]           winner;
    logic                    found;
    logic [FLIT_SIZE-1:0]    cur_flit;
    flit_type_t              cur_type;
    logic                    load;
    logic                    pop_fire;
    logic                    last_flit;
    logic                    proto_err;
    logic                    wd_expire;
    logic                    release_now;

    // Only a valid HEAD may open a packet; other request types are ignored.
    for (genvar i = 0; i < NUM_OF_PORTS; i++) begin : g_elig
        assign eligible[i] = req_i[i]
                           && flit_i[i*FLIT_SIZE + FLIT_SIZE - 1]
                           && (flit_i[i*FLIT_SIZE + FLIT_SIZE - 3 +: 2] == TYPE_HEAD);
    end

    // Round-robin scan starting at ptr: the first eligible input wins.
    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_OF_PORTS; k++) begin
            cand = PW'((int'(ptr) + k) % NUM_OF_PORTS);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign cur_flit  = flit_i[int'(gidx)*FLIT_SIZE +: FLIT_SIZE];
    assign cur_type  = flit_type_t'(cur_flit[FLIT_SIZE-2 -: 2]);
    assign load      = !out_valid || out_ready_i;
    assign pop_fire  = ((state == ACTIVE) || (state == WAITING))
                     && req_i[gidx] && cur_flit[FLIT_SIZE-1] && load;
    assign last_flit = (cnt == CW'(NUM_OF_FLITS - 1));

    // A HEAD inside a packet, or a full-length packet without a TAIL.
    assign proto_err = pop_fire && (((cur_type == TYPE_HEAD) && (cnt != '0))
                                 || (last_flit && (cur_type != TYPE_TAIL)));

`ifdef ROUTER_ARB_WATCHDOG_EN
    localparam int WW = $clog2(WD_TIMEOUT + 1);
    logic [WW-1:0] wd_cnt;

    // Counts stalled WAITING cycles. The cycle that would reach WD_TIMEOUT
    // releases the grant instead.
    assign wd_expire = (state == WAITING) && !pop_fire && (wd_cnt == WW'(WD_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if ((state == WAITING) && !pop_fire && !wd_expire) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // The grant is dropped on a TAIL or on forced termination. The output
    // register drains on its own.
    assign release_now = (pop_fire && ((cur_type == TYPE_TAIL) || last_flit)) || wd_expire;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            gidx      <= '0;
            ptr       <= '0;
            cnt       <= '0;
            out_flit  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (proto_err || wd_expire) begin
                err <= 1'b1;
            end

            if (pop_fire) begin
                out_flit  <= cur_flit;
                out_valid <= 1'b1;
            end else if (load) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= NUM_OF_PORTS'(1) << winner;
                        gidx  <= winner;
                        state <= ACTIVE;
                    end
                end
                ACTIVE, WAITING: begin
                    if (release_now) begin
                        state <= IDLE;
                        grant <= '0;
                        ptr   <= PW'((int'(gidx) + 1) % NUM_OF_PORTS);
                        cnt   <= '0;
                    end else if (pop_fire) begin
                        state <= ACTIVE;
                        cnt   <= cnt + 1'b1;
                    end else if (load) begin
                        // The flit is absent and the output has room, so park.
                        state <= WAITING;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pop_o       = pop_fire ? grant : '0;
    assign grant_o     = grant;
    assign out_flit_o  = out_flit;
    assign out_valid_o = out_valid;
    assign state_o     = state;
    assign err_o       = err;

endmodule

// File: tb/tb_router_out_arbiter.sv
// -----------------------------------------------------------------------------
// tb_router_out_arbiter
//
// Directed bench for router_out_arbiter. Each input is a small flit FIFO. A
// packet-level model runs at the falling edge and checks every output on every
// cycle. Hand-computed literal checks pin down latency, grant order,
// backpressure, WAITING, error and watchdog behaviour.
// -----------------------------------------------------------------------------
module tb_router_out_arbiter;

    localparam int NP = 4;
    localparam int FS = 19;
    localparam int WD = 64;
    localparam logic [1:0] TY_HEAD = 2'd0;
    localparam logic [1:0] TY_TAIL = 2'd1;
    localparam logic [1:0] TY_BODY = 2'd2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NP-1:0]    req_i = '0;
    logic [NP*FS-1:0] flit_i = '0;
    logic [NP-1:0]    pop_o;
    logic [NP-1:0]    grant_o;
    logic [FS-1:0]    out_flit_o;
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic [1:0]       state_o;
    logic             err_o;

    router_out_arbiter #(
        .NUM_OF_PORTS(NP), .FLIT_SIZE(FS), .NUM_OF_FLITS(4), .WD_TIMEOUT(WD)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .flit_i(flit_i), .pop_o(pop_o),
        .grant_o(grant_o), .out_flit_o(out_flit_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .state_o(state_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [FS-1:0] q[NP][$];
    logic [NP-1:0] hold = '0;
    logic [NP-1:0] pop_seen = '0;
    logic [FS-1:0] rx[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [FS-1:0] mk(input logic [1:0] ty, input logic [15:0] d);
        return {1'b1, ty, d};
    endfunction

    task automatic push_pkt(input int p, input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3, input logic [1:0] last_ty);
        q[p].push_back(mk(TY_HEAD, d0));
        q[p].push_back(mk(TY_BODY, d1));
        q[p].push_back(mk(TY_BODY, d2));
        q[p].push_back(mk(last_ty, d3));
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            req_i[i] = (q[i].size() > 0) && !hold[i];
            flit_i[i*FS +: FS] = (q[i].size() > 0) ? q[i][0] : '0;
        end
    endtask

    task automatic apply_pops();
        for (int i = 0; i < NP; i++)
            if (pop_seen[i] && q[i].size() > 0) void'(q[i].pop_front());
    endtask

    // Advance one cycle. Inputs and literal checks settle at posedge+2.
    task automatic cycle();
        @(posedge clk);
        #1;
        apply_pops();
        drive();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NP; i++) q[i].delete();
        hold = '0;
        out_ready_i = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    // ---------------- packet-level reference model ----------------
    int            m_owner = -1;
    int            m_ptr = 0;
    int            m_sent = 0;
    int            m_wd = 0;
    bit            m_wait = 0;
    bit            m_ovalid = 0;
    bit            m_err = 0;
    logic [FS-1:0] m_oflit = '0;
    logic [FS-1:0] mf;
    logic [FS-1:0] cf;
    logic [NP-1:0] exp_pop;
    bit            rdy_ok;
    int            idx;

    always @(negedge clk) begin
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_sent = 0; m_wd = 0;
            m_wait = 0; m_ovalid = 0; m_err = 0; m_oflit = '0;
            pop_seen = '0;
        end else begin
            rdy_ok  = !m_ovalid || out_ready_i;
            exp_pop = '0;
            mf      = '0;
            if (m_owner >= 0) begin
                mf = flit_i[m_owner*FS +: FS];
                if (req_i[m_owner] && mf[FS-1] && rdy_ok) exp_pop[m_owner] = 1'b1;
            end
            check("model grant", 32'(grant_o), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            check("model pop", 32'(pop_o), 32'(exp_pop));
            check("model state", 32'(state_o), (m_owner < 0) ? 32'd0 : (m_wait ? 32'd3 : 32'd2));
            check("model valid", 32'(out_valid_o), 32'(m_ovalid));
            check("model err", 32'(err_o), 32'(m_err));
            if (m_ovalid) check("model flit", 32'(out_flit_o), 32'(m_oflit));
            if (out_valid_o && out_ready_i) rx.push_back(out_flit_o);
            pop_seen = pop_o;

            if (m_owner < 0) begin
                if (rdy_ok) m_ovalid = 0;
                for (int k = 0; k < NP; k++) begin
                    idx = (m_ptr + k) % NP;
                    cf  = flit_i[idx*FS +: FS];
                    if (m_owner < 0 && req_i[idx] && cf[FS-1] && cf[FS-2 -: 2] == TY_HEAD) begin
                        m_owner = idx; m_sent = 0; m_wait = 0; m_wd = 0;
                    end
                end
            end else if (exp_pop != '0) begin
                m_oflit = mf; m_ovalid = 1; m_wait = 0; m_wd = 0;
                if (mf[FS-2 -: 2] == TY_HEAD && m_sent != 0) m_err = 1;
                m_sent++;
                if (mf[FS-2 -: 2] == TY_TAIL || m_sent == 4) begin
                    if (mf[FS-2 -: 2] != TY_TAIL) m_err = 1;
                    m_ptr = (m_owner + 1) % NP; m_owner = -1; m_sent = 0;
                end
            end else if (rdy_ok) begin
                m_ovalid = 0;
`ifdef ROUTER_ARB_WATCHDOG_EN
                if (m_wait) begin
                    m_wd++;
                    if (m_wd == WD) begin
                        m_err = 1; m_ptr = (m_owner + 1) % NP; m_owner = -1;
                        m_sent = 0; m_wait = 0; m_wd = 0;
                    end
                end
`endif
                if (m_owner >= 0) m_wait = 1;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [FS-1:0] t1_exp[4];
    logic [FS-1:0] t3_exp[4];
    logic [FS-1:0] held;
    logic [NP-1:0] prev_grant;
    int            gc[$];
    logic [NP-1:0] gg[$];

    initial begin
        // Reset state
        do_reset();
        check("reset grant", 32'(grant_o), 32'd0);
        check("reset pop", 32'(pop_o), 32'd0);
        check("reset state", 32'(state_o), 32'd0);
        check("reset valid", 32'(out_valid_o), 32'd0);
        check("reset flit", 32'(out_flit_o), 32'd0);
        check("reset err", 32'(err_o), 32'd0);

        // T1: single packet on input 0
        t1_exp[0] = mk(TY_HEAD, 16'h0012);
        t1_exp[1] = mk(TY_BODY, 16'hAAAA);
        t1_exp[2] = mk(TY_BODY, 16'hBBBB);
        t1_exp[3] = mk(TY_TAIL, 16'hCCCC);
        push_pkt(0, 16'h0012, 16'hAAAA, 16'hBBBB, 16'hCCCC, TY_TAIL);
        drive();
        for (int c = 1; c <= 6; c++) begin
            cycle();
            if (c == 1) check("t1 grant c1", 32'(grant_o), 32'h1);
            if (c >= 1 && c <= 4) check("t1 pop", 32'(pop_o), 32'h1);
            if (c >= 2 && c <= 5) check("t1 out flit", 32'(out_flit_o), 32'(t1_exp[c-2]));
            if (c == 5) check("t1 idle c5", 32'(state_o), 32'd0);
            if (c == 5) check("t1 err", 32'(err_o), 32'd0);
        end

        // T2: all four inputs request, round robin from ptr 0
        do_reset();
        for (int p = 0; p < NP; p++)
            push_pkt(p, 16'(16'h1000*p + 1), 16'(16'h1000*p + 2), 16'(16'h1000*p + 3),
                     16'(16'h1000*p + 4), TY_TAIL);
        drive();
        prev_grant = '0;
        gc.delete(); gg.delete();
        for (int c = 1; c <= 24; c++) begin
            cycle();
            if (grant_o != '0 && grant_o != prev_grant) begin
                gc.push_back(c); gg.push_back(grant_o);
            end
            prev_grant = grant_o;
            if (c == 5) check("t2 bubble", 32'(grant_o), 32'd0);
        end
        check("t2 grant count", 32'(gg.size()), 32'd4);
        t1_exp[0] = 19'h1; t1_exp[1] = 19'h2; t1_exp[2] = 19'h4;
        for (int k = 0; k < 3; k++) begin
            if (k < gg.size()) begin
                check("t2 grant order", 32'(gg[k]), 32'(t1_exp[k]));
                check("t2 grant cycle", 32'(gc[k]), 32'(1 + 5*k));
            end
        end

        // T3: backpressure mid-packet on input 2
        rx.delete();
        t3_exp[0] = mk(TY_HEAD, 16'h2001);
        t3_exp[1] = mk(TY_BODY, 16'h2002);
        t3_exp[2] = mk(TY_BODY, 16'h2003);
        t3_exp[3] = mk(TY_TAIL, 16'h2004);
        push_pkt(2, 16'h2001, 16'h2002, 16'h2003, 16'h2004, TY_TAIL);
        drive();
        for (int c = 1; c <= 12; c++) begin
            cycle();
            if (c == 3) begin
                out_ready_i = 1'b0;
                #1;
                held = out_flit_o;
                check("t3 stalled flit", 32'(out_flit_o), 32'(t3_exp[1]));
            end
            if (c == 6) out_ready_i = 1'b1;
            if (c >= 3 && c <= 5) begin
                check("t3 no pop", 32'(pop_o), 32'd0);
                check("t3 stable", 32'(out_flit_o), 32'(held));
                check("t3 valid held", 32'(out_valid_o), 32'd1);
            end
        end
        check("t3 flit count", 32'(rx.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < rx.size()) check("t3 rx order", 32'(rx[k]), 32'(t3_exp[k]));

        // T4: granted input 1 stalls for 5 cycles while input 3 waits
        push_pkt(1, 16'h3001, 16'h3002, 16'h3003, 16'h3004, TY_TAIL);
        drive();
        for (int c = 1; c <= 25; c++) begin
            cycle();
            if (c == 2) push_pkt(3, 16'h4001, 16'h4002, 16'h4003, 16'h4004, TY_TAIL);
            if (c == 3) hold[1] = 1'b1;
            if (c == 8) hold[1] = 1'b0;
            drive();
            #1;
            if (c >= 4 && c <= 7) begin
                check("t4 waiting", 32'(state_o), 32'd3);
                check("t4 grant held", 32'(grant_o), 32'h2);
            end
            if (c == 8) check("t4 resume pop", 32'(pop_o), 32'h2);
        end

        // T5: HEAD BODY BODY BODY on input 0, then a good packet on input 2
        push_pkt(0, 16'h5001, 16'h5002, 16'h5003, 16'h5004, TY_BODY);
        push_pkt(2, 16'h6001, 16'h6002, 16'h6003, 16'h6004, TY_TAIL);
        drive();
        for (int c = 1; c <= 15; c++) begin
            cycle();
            if (c == 1) check("t5 grant", 32'(grant_o), 32'h1);
            if (c == 4) check("t5 err before", 32'(err_o), 32'd0);
            if (c == 5) begin
                check("t5 err set", 32'(err_o), 32'd1);
                check("t5 released", 32'(state_o), 32'd0);
            end
            if (c == 6) check("t5 next grant", 32'(grant_o), 32'h4);
        end

        // T6: input 0 stalls after its HEAD
        do_reset();
        q[0].push_back(mk(TY_HEAD, 16'h7001));
        q[0].push_back(mk(TY_BODY, 16'h7002));
        drive();
`ifdef ROUTER_ARB_WATCHDOG_EN
        for (int c = 1; c <= 70; c++) begin
`else
        for (int c = 1; c <= 200; c++) begin
`endif
            cycle();
            if (c == 2) begin
                hold[0] = 1'b1;
                drive();
                #1;
            end
            if (c == 3) check("t6 enter waiting", 32'(state_o), 32'd3);
`ifdef ROUTER_ARB_WATCHDOG_EN
            if (c == 66) begin
                check("t6 wd pre state", 32'(state_o), 32'd3);
                check("t6 wd pre err", 32'(err_o), 32'd0);
            end
            if (c == 67) begin
                check("t6 wd state", 32'(state_o), 32'd0);
                check("t6 wd err", 32'(err_o), 32'd1);
                check("t6 wd grant", 32'(grant_o), 32'd0);
            end
`else
            if (c == 200) begin
                check("t6 still waiting", 32'(state_o), 32'd3);
                check("t6 grant kept", 32'(grant_o), 32'h1);
                check("t6 no err", 32'(err_o), 32'd0);
            end
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
